ft_restore: RTL and testbench

Core-side recovery engine for the lockstep fault-tolerance path. After the FT controller halts both cores on a write mismatch, this block copies the shadow register file back into both cores' register files, then restores the program counter from the shadow PC. It drives the shadow-register read address and consumes the returned data, broadcasting the writes to both cores. It signals completion so the controller can issue resume.

---
 rtl/ft_restore.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_ft_restore.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_restore.sv
// ---------------------------------------------------------------------------
// ft_restore
//
// Recovery engine for the lockstep fault-tolerance path. Once the FT
// controller has halted both cores, this block copies shadow registers
// 1..N-1 back into both cores' register files, restores the program counter
// from the shadow PC and then pulses done_o so the controller can resume.
//
// The copy is a two-stage pipeline. The read stage presents an index on
// sgpr_addr_o and captures the combinational shadow data. The write stage
// broadcasts that captured pair to both cores and holds it until
// rf_ready_i is seen. Register 0 is never read or written.
//
// Optional feature (macro FT_RESTORE_VERIFY_EN):
//   After the PC restore, every register 1..N-1 is read back from both
//   cores and compared against the shadow copy. Any difference sets fail_o,
//   which stays set until the next accepted start request.
//   Without the macro, the verify pass is absent. rf_raddr_o and fail_o are
//   tied to 0 and the core read-data inputs are ignored.
//
// Ports
//   clk_i         clock, rising edge
//   reset_i       synchronous active-high reset
//   start_i       restore request from the FT controller (rising edge taken)
//   sgpr_addr_o   shadow register file read address
//   sgpr_data_i   shadow register data (combinational read of sgpr_addr_o)
//   spc_i         shadow PC value
//   rf_we_o       register write strobe, broadcast to both cores
//   rf_addr_o     register write address
//   rf_wdata_o    register write data
//   rf_ready_i    both cores accept the write this cycle
//   pc_we_o       PC restore strobe, broadcast to both cores
//   pc_o          restored PC value
//   rf_raddr_o    core register read address (verify pass only)
//   rf_rdata_a_i  core A combinational register read data
//   rf_rdata_b_i  core B combinational register read data
//   busy_o        restore in progress
//   done_o        one-cycle completion pulse
//   fail_o        verify mismatch, sticky until the next start
// ---------------------------------------------------------------------------
module ft_restore #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] sgpr_addr_o,
    input  logic [DATA_WIDTH-1:0] sgpr_data_i,
    input  logic [DATA_WIDTH-1:0] spc_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    input  logic                  rf_ready_i,
    output logic                  pc_we_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
    input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COPY   = 3'd1,
        ST_PC     = 3'd2,
        ST_DONE   = 3'd3
`ifdef FT_RESTORE_VERIFY_EN
        ,
        ST_VERIFY = 3'd4
`endif
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;

    // Read stage: next shadow index to fetch, and whether any are left.
    logic [ADDR_WIDTH-1:0]   index_r;
    logic                    rd_pending_r;

    // Write stage: captured shadow pair waiting for both cores to accept.
    logic                    wr_valid_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic [DATA_WIDTH-1:0]   wr_data_r;

    // Start is taken on its rising edge so a level held high cannot
    // launch a second restore after the first one completes.
    logic                    start_prev_r;
    logic                    start_fire_s;

    logic                    advance_s;
    logic                    last_accept_s;

    logic                    busy_r;
    logic                    done_r;
    logic                    pc_we_r;
    logic [DATA_WIDTH-1:0]   pc_r;

    assign start_fire_s  = start_i & ~start_prev_r;
    assign advance_s     = ~wr_valid_r | rf_ready_i;
    assign last_accept_s = wr_valid_r & rf_ready_i & (wr_addr_r == LAST_IDX);

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_fire_s) begin
                    next_state_s = ST_COPY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_COPY: begin
                if (last_accept_s) begin
                    next_state_s = ST_PC;
                end else begin
                    next_state_s = ST_COPY;
                end
            end
            ST_PC: begin
`ifdef FT_RESTORE_VERIFY_EN
                next_state_s = ST_VERIFY;
`else
                next_state_s = ST_DONE;
`endif
            end
`ifdef FT_RESTORE_VERIFY_EN
            ST_VERIFY: begin
                if (index_r == LAST_IDX) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_VERIFY;
                end
            end
`endif
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Copy pipeline, index walk and start-edge tracking.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            index_r      <= ZERO_IDX;
            rd_pending_r <= 1'b0;
            wr_valid_r   <= 1'b0;
            wr_addr_r    <= ZERO_IDX;
            wr_data_r    <= ZERO_DATA;
            start_prev_r <= 1'b0;
        end else begin
            start_prev_r <= start_i;
            case (state_r)
                ST_IDLE: begin
                    if (start_fire_s) begin
                        index_r      <= FIRST_IDX;
                        rd_pending_r <= 1'b1;
                        wr_valid_r   <= 1'b0;
                    end else begin
                        index_r      <= ZERO_IDX;
                        rd_pending_r <= 1'b0;
                    end
                end
                ST_COPY: begin
                    // Everything freezes while the cores refuse the write.
                    if (advance_s) begin
                        if (rd_pending_r) begin
                            wr_valid_r <= 1'b1;
                            wr_addr_r  <= index_r;
                            wr_data_r  <= sgpr_data_i;
                            // Stop at the last index instead of wrapping to 0.
                            if (index_r == LAST_IDX) begin
                                rd_pending_r <= 1'b0;
                            end else begin
                                index_r <= index_r + FIRST_IDX;
                            end
                        end else begin
                            wr_valid_r <= 1'b0;
                            wr_addr_r  <= ZERO_IDX;
                            wr_data_r  <= ZERO_DATA;
                        end
                    end else begin
                        wr_valid_r <= wr_valid_r;
                    end
                    if (last_accept_s) begin
                        index_r <= ZERO_IDX;
                    end else begin
                        rd_pending_r <= rd_pending_r & ~(advance_s & (index_r == LAST_IDX));
                    end
                end
                ST_PC: begin
`ifdef FT_RESTORE_VERIFY_EN
                    index_r <= FIRST_IDX;
`else
                    index_r <= ZERO_IDX;
`endif
                end
`ifdef FT_RESTORE_VERIFY_EN
                ST_VERIFY: begin
                    if (index_r == LAST_IDX) begin
                        index_r <= ZERO_IDX;
                    end else begin
                        index_r <= index_r + FIRST_IDX;
                    end
                end
`endif
                ST_DONE: begin
                    index_r <= ZERO_IDX;
                end
                default: begin
                    index_r <= ZERO_IDX;
                end
            endcase
        end
    end

    // Status and PC outputs, registered from the upcoming state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pc_we_r <= 1'b0;
            pc_r    <= ZERO_DATA;
        end else begin
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
            pc_we_r <= (next_state_s == ST_PC);
            pc_r    <= (next_state_s == ST_PC) ? spc_i : ZERO_DATA;
        end
    end

`ifdef FT_RESTORE_VERIFY_EN
    logic fail_r;

    // Sticky read-back mismatch flag; cleared only by a new restore.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fail_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start_fire_s) begin
            fail_r <= 1'b0;
        end else if ((state_r == ST_VERIFY) &&
                     ((sgpr_data_i != rf_rdata_a_i) || (sgpr_data_i != rf_rdata_b_i))) begin
            fail_r <= 1'b1;
        end else begin
            fail_r <= fail_r;
        end
    end

    assign rf_raddr_o = index_r;
    assign fail_o     = fail_r;
`else
    logic unused_rdata_s;
    assign unused_rdata_s = ^{rf_rdata_a_i, rf_rdata_b_i};

    assign rf_raddr_o = ZERO_IDX;
    assign fail_o     = 1'b0;
`endif

    assign sgpr_addr_o = index_r;
    assign rf_we_o     = wr_valid_r;
    assign rf_addr_o   = wr_addr_r;
    assign rf_wdata_o  = wr_data_r;
    assign pc_we_o     = pc_we_r;
    assign pc_o        = pc_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_ft_restore.sv
// ---------------------------------------------------------------------------
// tb_ft_restore
//
// Directed bench for ft_restore. A cycle-level timeline model tracks the
// restore as phases (idle / copy / pc / verify / done) and the register
// currently being written; every cycle the DUT outputs are checked against
// it. Hand-computed cycle numbers pin the model (pc and done cycles, the held
// address under backpressure, write counts per register).
// ---------------------------------------------------------------------------
module tb_ft_restore;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 32;

    localparam int P_IDLE = 0;
    localparam int P_COPY = 1;
    localparam int P_PC   = 2;
    localparam int P_VER  = 3;
    localparam int P_DONE = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] sgpr_addr;
    logic [DW-1:0] sgpr_data;
    logic [DW-1:0] spc;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic          rf_ready;
    logic          pc_we;
    logic [DW-1:0] pc;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata_a;
    logic [DW-1:0] rf_rdata_b;
    logic          busy;
    logic          done;
    logic          fail;
    logic          inject;

    logic [DW-1:0] core_a [N];
    logic [DW-1:0] core_b [N];
    int            wr_count [N];

    int n_tests = 0;
    int n_fail  = 0;

    // timeline model state
    int m_phase;
    int m_wr;
    int m_vk;
    bit m_fail;
    bit m_start_prev;

    // per-run observations
    int cyc;
    int done_cyc;
    int pc_cyc;
    int done_cnt;
    int wr_total;
    int addr_c7;
    int or_c11;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] shadow(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    assign sgpr_data  = shadow(int'(sgpr_addr));
    assign rf_rdata_a = (inject && (rf_raddr == 5'd7)) ? 32'hDEAD_BEEF : core_a[rf_raddr];
    assign rf_rdata_b = core_b[rf_raddr];

    ft_restore #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .sgpr_addr_o  (sgpr_addr),
        .sgpr_data_i  (sgpr_data),
        .spc_i        (spc),
        .rf_we_o      (rf_we),
        .rf_addr_o    (rf_addr),
        .rf_wdata_o   (rf_wdata),
        .rf_ready_i   (rf_ready),
        .pc_we_o      (pc_we),
        .pc_o         (pc),
        .rf_raddr_o   (rf_raddr),
        .rf_rdata_a_i (rf_rdata_a),
        .rf_rdata_b_i (rf_rdata_b),
        .busy_o       (busy),
        .done_o       (done),
        .fail_o       (fail)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
        end
    endtask

    // Advance the timeline model by one clock using the inputs about to be sampled.
    task automatic model_advance();
        if (reset) begin
            m_phase = P_IDLE;
            m_wr    = 0;
            m_vk    = 0;
            m_fail  = 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: if (start && !m_start_prev) begin
                    m_phase = P_COPY;
                    m_wr    = 0;
                    m_fail  = 1'b0;
                end
                P_COPY: begin
                    if (m_wr == 0) m_wr = 1;
                    else if (rf_ready) begin
                        if (m_wr == N-1) m_phase = P_PC;
                        else m_wr++;
                    end
                end
                P_PC: begin
`ifdef FT_RESTORE_VERIFY_EN
                    m_phase = P_VER;
                    m_vk    = 1;
`else
                    m_phase = P_DONE;
`endif
                end
                P_VER: begin
                    if (inject && m_vk == 7) m_fail = 1'b1;
                    if (m_vk == N-1) m_phase = P_DONE;
                    else m_vk++;
                end
                default: m_phase = P_IDLE;
            endcase
        end
        m_start_prev = reset ? 1'b0 : start;
    endtask

    task automatic compare();
        bit exp_we;
        exp_we = (m_phase == P_COPY) && (m_wr != 0);
        chk("busy",     64'(busy),     64'(m_phase != P_IDLE));
        chk("rf_we",    64'(rf_we),    64'(exp_we));
        chk("rf_addr",  64'(rf_addr),  exp_we ? 64'(m_wr) : 64'd0);
        chk("rf_wdata", 64'(rf_wdata), exp_we ? 64'(shadow(m_wr)) : 64'd0);
        chk("pc_we",    64'(pc_we),    64'(m_phase == P_PC));
        chk("pc",       64'(pc),       (m_phase == P_PC) ? 64'(spc) : 64'd0);
        chk("done",     64'(done),     64'(m_phase == P_DONE));
        chk("fail",     64'(fail),     64'(m_fail));
        if (m_phase == P_COPY && m_wr + 1 <= N-1) chk("sgpr_addr", 64'(sgpr_addr), 64'(m_wr + 1));
        if (m_phase == P_IDLE) chk("sgpr_addr_idle", 64'(sgpr_addr), 64'd0);
`ifdef FT_RESTORE_VERIFY_EN
        if (m_phase == P_VER) begin
            chk("sgpr_addr_ver", 64'(sgpr_addr), 64'(m_vk));
            chk("rf_raddr_ver",  64'(rf_raddr),  64'(m_vk));
        end
        if (m_phase == P_IDLE) chk("rf_raddr_idle", 64'(rf_raddr), 64'd0);
`else
        chk("rf_raddr_tied", 64'(rf_raddr), 64'd0);
`endif
        if (done) done_cnt++;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (pc_we && pc_cyc < 0) pc_cyc = cyc;
        if (cyc == 7) addr_c7 = int'(rf_addr);
        if (cyc == 11) or_c11 = int'(busy | rf_we | pc_we | done | fail | (|sgpr_addr) | (|rf_addr) | (|rf_wdata) | (|pc));
    endtask

    // One clock: record accepted write, step model, then check after the edge.
    task automatic step();
        if (rf_we && rf_ready) begin
            wr_count[rf_addr]++;
            wr_total++;
            core_a[rf_addr] = rf_wdata;
            core_b[rf_addr] = rf_wdata;
        end
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic run(input int ncyc, input int start_len, input int start2,
                       input int st_lo, input int st_hi, input int rst_at, input bit inj);
        done_cyc = -1; pc_cyc = -1; done_cnt = 0; wr_total = 0;
        addr_c7 = -1; or_c11 = -1;
        for (int a = 0; a < N; a++) wr_count[a] = 0;
        inject = inj;
        cyc = 0;
        for (int i = 0; i < ncyc; i++) begin
            start    = (i < start_len) || (i == start2);
            rf_ready = !((i >= st_lo) && (i <= st_hi));
            reset    = (i == rst_at);
            step();
        end
        start = 1'b0; rf_ready = 1'b1; reset = 1'b0;
    endtask

    task automatic check_writes(input string nm);
        chk({nm, "_total"}, 64'(wr_total), 64'(N-1));
        for (int a = 0; a < N; a++) begin
            chk({nm, "_count"}, 64'(wr_count[a]), (a == 0) ? 64'd0 : 64'd1);
            if (a != 0) chk({nm, "_core"}, 64'(core_a[a]), 64'(shadow(a)));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rf_ready = 1'b1; spc = 32'h0000_0400; inject = 1'b0;
        for (int a = 0; a < N; a++) begin core_a[a] = '0; core_b[a] = '0; wr_count[a] = 0; end
        m_phase = P_IDLE; m_wr = 0; m_vk = 0; m_fail = 1'b0; m_start_prev = 1'b0;
        cyc = 0; done_cyc = -1; pc_cyc = -1; done_cnt = 0; wr_total = 0; addr_c7 = -1; or_c11 = -1;

        // reset state
        step(); step();
        chk("reset_outputs", 64'(busy | rf_we | pc_we | done | fail), 64'd0);
        reset = 1'b0;
        step();

        // full restore, no stalls
        run(40, 1, -1, -1, -1, -1, 1'b0);
        chk("full_pc_cycle", 64'(pc_cyc), 64'd33);
`ifdef FT_RESTORE_VERIFY_EN
        chk("full_done_cycle", 64'(done_cyc), 64'd65);
`else
        chk("full_done_cycle", 64'(done_cyc), 64'd34);
`endif
        chk("full_done_count", 64'(done_cnt), 64'd1);
        check_writes("full");

        // backpressure in cycles 5..7
        run(45, 1, -1, 5, 7, -1, 1'b0);
        chk("bp_hold_addr", 64'(addr_c7), 64'd4);
        chk("bp_pc_cycle", 64'(pc_cyc), 64'd36);
`ifndef FT_RESTORE_VERIFY_EN
        chk("bp_done_cycle", 64'(done_cyc), 64'd37);
`endif
        check_writes("bp");

        // reset in cycle 10, then a fresh restore from register 1
        run(14, 1, -1, -1, -1, 10, 1'b0);
        chk("rst_cycle11_idle", 64'(or_c11), 64'd0);
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        run(40, 1, -1, -1, -1, -1, 1'b0);
        check_writes("rst_again");

        // start held high for 40 cycles: one restore only
        run(80, 40, -1, -1, -1, -1, 1'b0);
        chk("held_done_count", 64'(done_cnt), 64'd1);
        check_writes("held");

        // second pulse while busy is ignored and not queued
        run(80, 1, 15, -1, -1, -1, 1'b0);
        chk("busy_start_done_count", 64'(done_cnt), 64'd1);
        check_writes("busy_start");

        // reset and start together: reset wins
        run(4, 1, -1, -1, -1, 0, 1'b0);
        chk("rst_start_no_write", 64'(wr_total), 64'd0);
        chk("rst_start_idle", 64'(busy), 64'd0);

`ifdef FT_RESTORE_VERIFY_EN
        // core A register 7 corrupted during read-back
        run(70, 1, -1, -1, -1, -1, 1'b1);
        chk("ver_bad_done_cycle", 64'(done_cyc), 64'd65);
        chk("ver_bad_fail", 64'(fail), 64'd1);
        run(3, 1, -1, -1, -1, -1, 1'b0);
        chk("ver_fail_cleared", 64'(fail), 64'd0);
        run(70, 0, -1, -1, -1, -1, 1'b0);
        // clean read-back
        run(70, 1, -1, -1, -1, -1, 1'b0);
        chk("ver_ok_done_cycle", 64'(done_cyc), 64'd65);
        chk("ver_ok_fail", 64'(fail), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
